// File: rtl/counter_sequencer_if.sv
// Counter datapath bus: strobes and preload value toward the counter, count back from it.
interface counter_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             ctr_ld;
  logic             ctr_en;
  logic [WIDTH-1:0] ctr_v;
  logic [WIDTH-1:0] count;

  modport master (output ctr_ld, output ctr_en, output ctr_v, input count);
  modport slave  (input ctr_ld, input ctr_en, input ctr_v, output count);
endinterface

// File: rtl/counter_sequencer.sv
// Control FSM that loads, paces and terminates an external WIDTH-bit up-counter,
// in one-shot or continuous (auto-reload) mode with a programmable prescaler.
module counter_sequencer #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   oneshot,
  input  logic [WIDTH-1:0]       preload,
  input  logic [WIDTH-1:0]       limit,
  input  logic [DIV_W-1:0]       div,
  counter_sequencer_if.master    ctr,
  output logic                   busy,
  output logic                   tick,
  output logic                   done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [DIV_W-1:0] r_pre;
  logic [WIDTH-1:0] r_preload_q;
  logic [WIDTH-1:0] r_limit_q;
  logic [DIV_W-1:0] r_div_q;
  logic             r_oneshot_q;

  logic             w_capture;
  logic             w_slot;
  logic             w_term;

  // Strobes depend only on state, prescaler, count feedback and captured config.
  assign w_slot = (r_state == S_RUN) && (r_pre == r_div_q);
  assign w_term = w_slot && (ctr.count == r_limit_q);

  assign ctr.ctr_ld = (r_state == S_LOAD) || (w_term && !r_oneshot_q);
  assign ctr.ctr_en = w_slot && !w_term;
  assign ctr.ctr_v  = r_preload_q;
  assign busy       = (r_state == S_LOAD) || (r_state == S_RUN);
  assign tick       = w_term;
  assign done       = (r_state == S_DONE);

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !stop) begin
          w_state_nxt = S_LOAD;
          w_capture   = 1'b1;
        end
      end
      S_LOAD: begin
        w_state_nxt = stop ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        // Abort takes priority over the terminal one-shot transition.
        if (stop) begin
          w_state_nxt = S_IDLE;
        end else if (w_term && r_oneshot_q) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pre       <= '0;
      r_preload_q <= '0;
      r_limit_q   <= '0;
      r_div_q     <= '0;
      r_oneshot_q <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_capture) begin
        r_preload_q <= preload;
        r_limit_q   <= limit;
        r_div_q     <= div;
        r_oneshot_q <= oneshot;
      end
      // Prescaler restarts at every load so the first slot lands div_q cycles into RUN.
      if (r_state == S_LOAD) begin
        r_pre <= '0;
      end else if (r_state == S_RUN) begin
        r_pre <= w_slot ? '0 : r_pre + 1'b1;
      end
    end
  end

endmodule
